// File: rtl/ej32_boot_loader.sv
// Boot loader ahead of the eJ32 core: copies the eForth ROM image into RAM,
// holds the core in reset until the copy completes, and reports cold vector and checksum.
module ej32_boot_loader #(
  parameter int unsigned MEM0     = 'h0,
  parameter int unsigned ROM_SZ   = 8192,
  parameter int unsigned ROM_WAIT = 3,
  parameter int unsigned ASZ      = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           reload,
  output logic [ASZ-1:0] rom_a,
  input  logic [7:0]     rom_d,
  output logic           ram_we,
  output logic [ASZ-1:0] ram_a,
  output logic [7:0]     ram_d,
  output logic           core_hold,
  output logic           busy,
  output logic           done,
  output logic [15:0]    cold,
  output logic [7:0]     csum,
  output logic [1:0]     dbg_state
);

  localparam int unsigned OW = $clog2(ROM_SZ);
  localparam int unsigned WW = (ROM_WAIT < 2) ? 1 : $clog2(ROM_WAIT + 1);
  localparam logic [OW-1:0] LAST  = OW'(ROM_SZ - 1);
  localparam logic [WW-1:0] WLOAD = WW'(ROM_WAIT);

  // Encoding is visible on dbg_state: IDLE=0 FETCH=1 WRITE=2 DONE=3.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [OW-1:0]  offset_q, offset_d;
  logic [WW-1:0]  wcnt_q, wcnt_d;
  logic [7:0]     byte_q, byte_d;
  logic [7:0]     csum_q, csum_d;
  logic [15:0]    cold_q, cold_d;
  logic           hold_q, hold_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      offset_q <= '0;
      wcnt_q   <= '0;
      byte_q   <= '0;
      csum_q   <= '0;
      cold_q   <= '0;
      hold_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      wcnt_q   <= wcnt_d;
      byte_q   <= byte_d;
      csum_q   <= csum_d;
      cold_q   <= cold_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    wcnt_d   = wcnt_q;
    byte_d   = byte_q;
    csum_d   = csum_q;
    cold_d   = cold_q;
    hold_d   = hold_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        wcnt_d  = WLOAD;
      end
      S_FETCH: begin
        // rom_a has been stable since entry; sample once the wait has elapsed.
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WW'(1);
        end else begin
          byte_d  = rom_d;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        csum_d = csum_q + byte_q;
        if (offset_q == OW'(1)) cold_d[15:8] = byte_q;
        if (offset_q == OW'(2)) cold_d[7:0]  = byte_q;
        if (offset_q == LAST) begin
          state_d = S_DONE;
          hold_d  = 1'b0;
        end else begin
          offset_d = offset_q + OW'(1);
          wcnt_d   = WLOAD;
          state_d  = S_FETCH;
        end
      end
      S_DONE: begin
        if (reload) begin
          hold_d   = 1'b1;
          offset_d = '0;
          csum_d   = '0;
          cold_d   = '0;
          wcnt_d   = WLOAD;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // busy covers the IDLE cycle right after release, hence the rst term.
  assign busy      = ((state_q == S_IDLE) && rst) || (state_q == S_FETCH) || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign ram_we    = (state_q == S_WRITE);
  assign rom_a     = ASZ'(offset_q);
  assign ram_a     = ASZ'(MEM0) + ASZ'(offset_q);
  assign ram_d     = byte_q;
  assign core_hold = hold_q;
  assign cold      = cold_q;
  assign csum      = csum_q;
  assign dbg_state = state_q;

endmodule

// File: doc/ej32_boot_loader.md
Name: ej32_boot_loader

Overview:
- Bootstrap stage directly upstream of the eJ32 core.
- After reset it copies the hosted eForth ROM image byte-by-byte into RAM starting at MEM0, honouring the ROM read wait time.
- It holds the core in reset until the image is complete, then releases it to cold-start from the address stored in image bytes 0x01..0x02.
- It also exposes the cold-start vector and an 8-bit additive checksum of the image for the verification bench.

Parameters:
- MEM0, 'h0, RAM base address of the image.
- ROM_SZ, 8192, image size in bytes (>=4).
- ROM_WAIT, 3, cycles from ROM address change until rom_d is stable (>=0).
- ASZ, 17, width of ROM and RAM byte addresses.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- reload  in  1  single-cycle request to re-copy the image; honoured only in DONE.
- rom_a  out  ASZ  ROM byte address.
- rom_d  in  8  ROM byte data; valid ROM_WAIT cycles after rom_a changes.
- ram_we  out  1  RAM byte write strobe.
- ram_a  out  ASZ  RAM byte address (MEM0 + offset).
- ram_d  out  8  RAM write data.
- core_hold  out  1  holds the eJ32 core in reset while 1.
- busy  out  1  copy in progress.
- done  out  1  image complete and valid.
- cold  out  16  cold-start vector, {byte1, byte2} big-endian.
- csum  out  8  running sum mod 256 of all bytes written.

Behaviour:

Reset (rst==0 sampled on a clk edge):
- state=IDLE; offset=0; wcnt=0.
- rom_a=0, ram_we=0, ram_a=MEM0, ram_d=0.
- core_hold=1, busy=0, done=0, cold=0, csum=0.
- Reset asserted mid-copy aborts immediately; no further writes occur. The copy restarts from offset 0 after release. Partially written RAM is not cleared.

States:
- IDLE: entered only from reset. On the first cycle with rst==1, go to FETCH with wcnt=ROM_WAIT. In that cycle rom_a=offset=0 and busy=1.
- FETCH: rom_a=offset.
  - If wcnt!=0: wcnt--.
  - If wcnt==0: capture rom_d into ram_d; go to WRITE.
  - With ROM_WAIT=0 FETCH lasts exactly 1 cycle.
- WRITE: 1 cycle with ram_we=1, ram_a=MEM0+offset, ram_d=captured byte. On that edge:
  - csum += byte, mod 256.
  - If offset==1, cold[15:8]=byte; if offset==2, cold[7:0]=byte.
  - If offset==ROM_SZ-1: go to DONE.
  - Otherwise offset++, wcnt=ROM_WAIT, go to FETCH.
- DONE: busy=0, done=1, ram_we=0.
  - core_hold drops to 0 on the same edge that enters DONE.
  - reload==1: core_hold=1, done=0, busy=1, offset=0, csum=0, cold=0, wcnt=ROM_WAIT, go to FETCH.

Timing:
- Per byte: ROM_WAIT+2 cycles (FETCH ROM_WAIT+1, WRITE 1).
- Total from reset release to done=1: 1 + ROM_SZ*(ROM_WAIT+2) cycles, including the IDLE cycle.
- Exactly ROM_SZ write strobes per copy.
- ram_a is strictly increasing, with no repeats or gaps.

Other rules:
- reload while busy or in IDLE is ignored; it is not queued.
- ram_we is never 1 outside WRITE.
- rom_a is stable throughout FETCH and WRITE of a byte.
- The offset counter is sized ceil(log2(ROM_SZ)). The last address MEM0+ROM_SZ-1 must not wrap within ASZ.
- done, cold and csum hold their values in DONE until reload or reset.

Test Plan:
- Small image and checksum: ROM_SZ=16, ROM_WAIT=3, ROM[i]=i+1, MEM0=0 -> 16 strobes at ram_a 0..15 with ram_d 1..16; done=1 at cycle 1+16*5=81 after release; cold=16'h0203; csum=8'h88; core_hold falls on the same edge.
- Zero wait: ROM_WAIT=0, ROM_SZ=8, MEM0='h100 -> strobes every 2nd cycle at 'h100..'h107; done at cycle 17.
- Reset mid-copy: assert rst=0 after the 5th strobe, release 3 cycles later -> no strobes while rst==0; copy restarts at offset 0; total strobes after release=ROM_SZ; csum matches the full image.
- Reload: pulse reload in DONE -> core_hold=1 and done=0 next cycle; full image re-copied; csum and cold identical to the first pass. Reload pulsed while busy -> ignored; strobe count unchanged.
- Full image: ROM_SZ=8192, ROM_WAIT=3, ROM byte1:2 = 'h20:'h00 -> cold='h2000; 8192 strobes; done at cycle 40961; bench RAM copy equals the ROM byte-for-byte.
